// File: rtl/push_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : push_arbiter_pkg
// Brief   : Shared types and constants for the tug-of-war push arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package push_arbiter_pkg;

  localparam int CNT_W        = 16;
  localparam int HOLDOFF_DEF  = 16;
  localparam int DEBOUNCE_DEF = 4;

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    ARMED        = 2'd1,
    LOCKOUT      = 2'd2
  } state_t;

endpackage : push_arbiter_pkg
`default_nettype wire

// File: rtl/push_arbiter_button_sync.sv
`default_nettype none
// ============================================================================
// Module  : button_sync
// Brief   : 2-flop synchroniser, optional debounce (PUSH_ARBITER_DEBOUNCE_EN)
//           and rising-edge detect for one raw push-button.
// Rev     : 1.0  initial release
// ============================================================================
module button_sync
  import push_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic level,
  output logic rise,
  output logic ready
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("button_sync: DEBOUNCE_CYCLES out of range");
  end

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_primed;
  logic       w_level;
  logic       w_stable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_prev   <= 1'b0;
      r_primed <= 2'b00;
    end else begin
      r_meta   <= pb;
      r_sync   <= r_meta;
      r_prev   <= w_level;
      r_primed <= {r_primed[0], 1'b1};
    end
  end

`ifdef PUSH_ARBITER_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_deb;
  logic [CNT_W-1:0] r_deb_cnt;

  // Counter runs only while the synced level disagrees with the accepted one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == c_deb_last) begin
      r_deb     <= r_sync;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_level  = r_deb;
  assign w_stable = (r_deb_cnt == '0) && (r_sync == r_deb);
`else
  assign w_level  = r_sync;
  assign w_stable = 1'b1;
`endif

  assign level = w_level;
  assign rise  = w_level & ~r_prev;
  // Pipeline must have seen the raw pin before a 0 level can be trusted
  assign ready = r_primed[1] & (r_meta == r_sync) & w_stable;

endmodule : button_sync
`default_nettype wire

// File: rtl/push_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : push_arbiter
// Brief   : First-press referee with lockout; optional debounce build macro
//           PUSH_ARBITER_DEBOUNCE_EN.
// Rev     : 1.0  initial release
// ============================================================================
module push_arbiter
  import push_arbiter_pkg::*;
#(
  parameter int HOLDOFF         = HOLDOFF_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_l,
  input  logic pb_r,
  input  logic leds_on,
  input  logic en,
  output logic winrnd,
  output logic right,
  output logic tie,
  output logic leds_at_push,
  output logic busy
);

  if (HOLDOFF < 1 || HOLDOFF > 65535) begin : g_bad_holdoff
    $error("push_arbiter: HOLDOFF out of range");
  end

  localparam logic [CNT_W-1:0] c_holdoff = CNT_W'(HOLDOFF);

  logic w_level_l, w_rise_l, w_ready_l;
  logic w_level_r, w_rise_r, w_ready_r;

  button_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_l (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb_l),
    .level (w_level_l),
    .rise  (w_rise_l),
    .ready (w_ready_l)
  );

  button_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_r (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb_r),
    .level (w_level_r),
    .rise  (w_rise_r),
    .ready (w_ready_r)
  );

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_decide;
  logic             r_winrnd, r_right, r_tie, r_leds;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WAIT_RELEASE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_decide    = 1'b0;
    case (r_state)
      WAIT_RELEASE: begin
        if (w_ready_l && w_ready_r && !w_level_l && !w_level_r)
          w_state_nxt = ARMED;
      end
      ARMED: begin
        if (en && (w_rise_l || w_rise_r)) begin
          w_decide    = 1'b1;
          w_cnt_nxt   = c_holdoff;
          w_state_nxt = LOCKOUT;
        end
      end
      LOCKOUT: begin
        // Leave only after the zero count has been observed; never wraps
        if (r_cnt == '0)
          w_state_nxt = WAIT_RELEASE;
        else
          w_cnt_nxt = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = WAIT_RELEASE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_winrnd <= 1'b0;
      r_right  <= 1'b0;
      r_tie    <= 1'b0;
      r_leds   <= 1'b0;
    end else begin
      r_winrnd <= w_decide;
      if (w_decide) begin
        r_right <= w_rise_r & ~w_rise_l;
        r_tie   <= w_rise_r &  w_rise_l;
        r_leds  <= leds_on;
      end
    end
  end

  assign winrnd       = r_winrnd;
  assign right        = r_right;
  assign tie          = r_tie;
  assign leds_at_push = r_leds;
  assign busy         = (r_state != ARMED);

endmodule : push_arbiter
`default_nettype wire

// File: tb/tb_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_push_arbiter
// Brief   : Directed self-checking bench for push_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_push_arbiter;

  localparam int HOLD = 16;
`ifdef PUSH_ARBITER_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam int LAT = 3 + DEB;
`else
  localparam int DEB = 4;
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst, pb_l, pb_r, leds_on, en;
  logic winrnd, right, tie, leds_at_push, busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  push_arbiter #(.HOLDOFF(HOLD), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .pb_l         (pb_l),
    .pb_r         (pb_r),
    .leds_on      (leds_on),
    .en           (en),
    .winrnd       (winrnd),
    .right        (right),
    .tie          (tie),
    .leds_at_push (leds_at_push),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (winrnd === 1'b1) pulses++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; pb_l = 1'b1; pb_r = 1'b0; leds_on = 1'b0; en = 1'b1;
    cyc(3);
    check("rst_busy", busy, 1);
    check("rst_winrnd", winrnd, 0);
    check("rst_right", right, 0);
    check("rst_tie", tie, 0);
    check("rst_leds", leds_at_push, 0);

    // Release reset with left still held: must not arm or fire
    rst = 1'b1;
    pulses = 0;
    cyc(10);
    check("held_no_win", pulses, 0);
    check("held_busy", busy, 1);

    pb_l = 1'b0;
    cyc(LAT - 1);
    check("release_busy_early", busy, 1);
    cyc(1);
    check("release_busy", busy, 0);

    // Right press with lights on
    pb_r = 1'b1; leds_on = 1'b1;
    cyc(LAT - 1);
    check("r_win_early", winrnd, 0);
    cyc(1);
    check("r_winrnd", winrnd, 1);
    check("r_right", right, 1);
    check("r_tie", tie, 0);
    check("r_leds", leds_at_push, 1);
    check("r_busy", busy, 1);
    pb_r = 1'b0;
    cyc(1);
    check("r_pulse_end", winrnd, 0);
    check("r_right_held", right, 1);
    pulses = 0;
    cyc(24);
    check("r_no_extra", pulses, 0);
    check("r_rearmed", busy, 0);

    // Simultaneous press
    pb_l = 1'b1; pb_r = 1'b1;
    cyc(LAT);
    check("tie_winrnd", winrnd, 1);
    check("tie_tie", tie, 1);
    check("tie_right", right, 0);
    pb_l = 1'b0; pb_r = 1'b0;
    pulses = 0;
    cyc(25);
    check("tie_single", pulses, 0);
    check("tie_rearmed", busy, 0);

    // Left jumps the light, then presses again during lockout
    pb_l = 1'b1; leds_on = 1'b0;
    cyc(LAT);
    check("l_winrnd", winrnd, 1);
    check("l_right", right, 0);
    check("l_tie", tie, 0);
    check("l_leds", leds_at_push, 0);
    pb_l = 1'b0;
    cyc(2);
    pb_l = 1'b1;
    pulses = 0;
    cyc(25);
    check("lockout_ignored", pulses, 0);
    check("wait_release_busy", busy, 1);
    pb_l = 1'b0;
    cyc(LAT);
    check("l_rearmed", busy, 0);

    // Disabled round, then held left cannot beat a fresh right
    en = 1'b0; pb_l = 1'b1;
    pulses = 0;
    cyc(10);
    check("en0_no_win", pulses, 0);
    check("en0_busy", busy, 0);
    en = 1'b1;
    cyc(3);
    check("held_l_no_win", pulses, 0);
    pb_r = 1'b1; leds_on = 1'b1;
    cyc(LAT);
    check("held_winrnd", winrnd, 1);
    check("held_right", right, 1);
    check("held_tie", tie, 0);

    // Asynchronous reset in the middle of lockout
    cyc(5);
    check("mid_lock_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("arst_winrnd", winrnd, 0);
    check("arst_right", right, 0);
    check("arst_tie", tie, 0);
    check("arst_leds", leds_at_push, 0);
    check("arst_busy", busy, 1);
    pb_l = 1'b0; pb_r = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(LAT + 3);
    check("post_rst_armed", busy, 0);

`ifdef PUSH_ARBITER_DEBOUNCE_EN
    pb_r = 1'b1;
    cyc(2);
    pb_r = 1'b0;
    pulses = 0;
    cyc(20);
    check("glitch_no_win", pulses, 0);
    check("glitch_busy", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_push_arbiter
`default_nettype wire
